// File: rtl/branch_ex_mem.sv
// branch_ex_mem: EX/MEM boundary buffer with branch resolution.
//
// A two-entry FIFO carries non-branch EX results to the MEM stage. Conditional
// branches are consumed here: their condition is evaluated from the ALU flags
// and a taken branch raises a one-cycle redirect pulse with the target PC.
// Branches never occupy a FIFO slot.
//
// Handshake: a transfer happens on a cycle where valid and ready are both high
// at the rising edge. in_ready and out_valid are decoded from the registered
// FSM state only, so neither depends combinationally on the other side.
//
// Optional feature: define UNSIGNED_BRANCH_EN to resolve bltu (110) and
// bgeu (111) from alu_cout; otherwise those codes are never taken.
module branch_ex_mem #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            alu_less,
    input  logic            alu_cout,
    input  logic            is_branch,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd_addr,
    input  logic [2:0]      ctl,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_ctl,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      fsm_state
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic            wr_ptr;
    logic            rd_ptr;
    logic            push;
    logic            pop;
    logic            br_accept;
    logic            taken;

    logic [XLEN-1:0] res_mem [DEPTH];
    logic [XLEN-1:0] sd_mem  [DEPTH];
    logic [4:0]      rd_mem  [DEPTH];
    logic [2:0]      ctl_mem [DEPTH];

    assign in_ready  = (state != S_FULL);
    assign out_valid = (state != S_EMPTY);
    assign fsm_state = state;

    // A flush cycle accepts nothing, so a branch seen with flush never redirects.
    assign push      = in_valid & in_ready & ~is_branch & ~flush;
    assign br_accept = in_valid & in_ready &  is_branch & ~flush;
    assign pop       = out_valid & out_ready;

    // Branch condition from the ALU flags.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = alu_zero;
            3'b001:  taken = ~alu_zero;
            3'b100:  taken = alu_less;
            3'b101:  taken = ~alu_less;
`ifdef UNSIGNED_BRANCH_EN
            3'b110:  taken = ~alu_cout;
            3'b111:  taken = alu_cout;
`endif
            default: taken = 1'b0;
        endcase
    end

`ifndef UNSIGNED_BRANCH_EN
    // Carry-out only matters for unsigned compares.
    logic unused_cout;
    assign unused_cout = alu_cout;
`endif

    // Occupancy transitions; flush overrides everything and empties the buffer.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: if (push) state_next = S_ONE;
                S_ONE: begin
                    if (push && !pop)      state_next = S_FULL;
                    else if (!push && pop) state_next = S_EMPTY;
                    else                   state_next = S_ONE;
                end
                S_FULL:  if (pop) state_next = S_ONE;
                default: state_next = S_EMPTY;
            endcase
        end
    end

    // State and pointer registers; pointers are 1 bit so they wrap modulo 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            state <= state_next;
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Entry storage; cleared on reset so the head fields read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                res_mem[i] <= '0;
                sd_mem[i]  <= '0;
                rd_mem[i]  <= '0;
                ctl_mem[i] <= '0;
            end
        end else if (push) begin
            res_mem[wr_ptr] <= alu_result;
            sd_mem[wr_ptr]  <= store_data;
            rd_mem[wr_ptr]  <= rd_addr;
            ctl_mem[wr_ptr] <= ctl;
        end
    end

    // Redirect pulse one cycle after a taken branch is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= br_accept & taken;
            if (br_accept && taken) redirect_pc <= br_target;
        end
    end

    // Head entry; the slot under rd_ptr is never written while it is the head.
    assign out_result     = res_mem[rd_ptr];
    assign out_store_data = sd_mem[rd_ptr];
    assign out_rd         = rd_mem[rd_ptr];
    assign out_ctl        = ctl_mem[rd_ptr];

endmodule

// File: tb/tb_branch_ex_mem.sv
// tb_branch_ex_mem: directed table, hand sequences and random traffic for
// branch_ex_mem, checked against a queue/operand-level reference model.
module tb_branch_ex_mem;
    localparam int XLEN = 64;
    localparam int EW   = 2 * XLEN + 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] alu_result = '0;
    logic            alu_zero = 1'b0;
    logic            alu_less = 1'b0;
    logic            alu_cout = 1'b0;
    logic            is_branch = 1'b0;
    logic [2:0]      funct3 = '0;
    logic [XLEN-1:0] br_target = '0;
    logic [XLEN-1:0] store_data = '0;
    logic [4:0]      rd_addr = '0;
    logic [2:0]      ctl = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_result;
    logic [XLEN-1:0] out_store_data;
    logic [4:0]      out_rd;
    logic [2:0]      out_ctl;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      fsm_state;

    // operands behind the ALU flags of the current branch
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;

    // reference model
    logic [EW-1:0]   exp_q[$];
    logic            exp_redir = 1'b0;
    logic [XLEN-1:0] exp_pc = '0;

    int errors = 0;
    int checks = 0;

    branch_ex_mem #(.XLEN(XLEN), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_less(alu_less),
        .alu_cout(alu_cout), .is_branch(is_branch), .funct3(funct3),
        .br_target(br_target), .store_data(store_data), .rd_addr(rd_addr),
        .ctl(ctl), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data),
        .out_rd(out_rd), .out_ctl(out_ctl), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fsm_state(fsm_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // branch outcome from the operands themselves
    function automatic logic model_taken(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (f)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return $signed(a) >= $signed(b);
`ifdef UNSIGNED_BRANCH_EN
            3'b110: return a < b;
            3'b111: return a >= b;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_redir = 1'b0;
        exp_pc    = '0;
    endtask

    // compare every visible output with the model
    task automatic compare();
        logic [EW-1:0] h;
        chk("in_ready", XLEN'(in_ready), XLEN'(exp_q.size() < 2));
        chk("out_valid", XLEN'(out_valid), XLEN'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            chk("out_result", out_result, h[EW-1 -: XLEN]);
            chk("out_store_data", out_store_data, h[XLEN+7 -: XLEN]);
            chk("out_rd", XLEN'(out_rd), XLEN'(h[7:3]));
            chk("out_ctl", XLEN'(out_ctl), XLEN'(h[2:0]));
        end
        chk("redirect_valid", XLEN'(redirect_valid), XLEN'(exp_redir));
        if (exp_redir) chk("redirect_pc", redirect_pc, exp_pc);
    endtask

    // advance one clock: update model from current inputs, then compare
    task automatic tick();
        int   sz;
        logic nr;
        sz = exp_q.size();
        nr = 1'b0;
        if (rst_n) begin
            if (flush) begin
                exp_q.delete();
            end else begin
                if (sz > 0 && out_ready) void'(exp_q.pop_front());
                if (in_valid && sz < 2) begin
                    if (is_branch) begin
                        if (model_taken(funct3, op_a, op_b)) begin
                            nr     = 1'b1;
                            exp_pc = br_target;
                        end
                    end else begin
                        exp_q.push_back({alu_result, store_data, rd_addr, ctl});
                    end
                end
            end
            exp_redir = nr;
        end
        @(posedge clk);
        #1;
        compare();
    endtask

    // driver tasks
    task automatic idle();
        in_valid  = 1'b0;
        is_branch = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic set_entry(input logic [XLEN-1:0] r, input logic [XLEN-1:0] sd,
                             input logic [4:0] rd, input logic [2:0] c);
        in_valid   = 1'b1;
        is_branch  = 1'b0;
        alu_result = r;
        store_data = sd;
        rd_addr    = rd;
        ctl        = c;
    endtask

    task automatic set_branch(input logic [2:0] f, input logic [XLEN-1:0] a,
                              input logic [XLEN-1:0] b, input logic [XLEN-1:0] tgt);
        in_valid   = 1'b1;
        is_branch  = 1'b1;
        funct3     = f;
        op_a       = a;
        op_b       = b;
        alu_result = a - b;
        alu_zero   = (a == b);
        alu_less   = ($signed(a) < $signed(b));
        alu_cout   = (a >= b);
        br_target  = tgt;
    endtask

    function automatic logic [XLEN-1:0] rand_op();
        logic [XLEN-1:0] v;
        v = XLEN'($urandom_range(0, 3));
        if ($urandom_range(0, 2) == 0) v = -v;
        return v;
    endfunction

    typedef struct {
        logic [2:0]      f3;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            exp_signed_build;
        logic            exp_unsigned_build;
    } br_vec_t;

    br_vec_t vecs [13];

    initial begin
        logic [XLEN-1:0] m1;
        logic            exp_t;
        m1 = '1;

        vecs[0]  = '{3'b000, 64'd7, 64'd7, 1'b1, 1'b1};
        vecs[1]  = '{3'b000, 64'd7, 64'd8, 1'b0, 1'b0};
        vecs[2]  = '{3'b001, 64'd7, 64'd8, 1'b1, 1'b1};
        vecs[3]  = '{3'b001, 64'd7, 64'd7, 1'b0, 1'b0};
        vecs[4]  = '{3'b100, 64'd1, 64'd2, 1'b1, 1'b1};
        vecs[5]  = '{3'b100, 64'd5, -64'd3, 1'b0, 1'b0};
        vecs[6]  = '{3'b101, 64'd5, -64'd3, 1'b1, 1'b1};
        vecs[7]  = '{3'b101, 64'd1, 64'd2, 1'b0, 1'b0};
        vecs[8]  = '{3'b110, 64'd1, m1, 1'b0, 1'b1};
        vecs[9]  = '{3'b111, 64'd5, 64'd3, 1'b0, 1'b1};
        vecs[10] = '{3'b111, 64'd1, 64'd2, 1'b0, 1'b0};
        vecs[11] = '{3'b010, 64'd1, 64'd2, 1'b0, 1'b0};
        vecs[12] = '{3'b011, 64'd7, 64'd7, 1'b0, 1'b0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        compare();
        chk("reset out_result", out_result, '0);
        chk("reset redirect_pc", redirect_pc, '0);
        chk("reset fsm_state", XLEN'(fsm_state), '0);
        rst_n = 1'b1;

        // single entry, one-cycle latency
        out_ready = 1'b1;
        set_entry(64'h5, 64'h0, 5'd3, 3'b100);
        tick();
        chk("first out_result", out_result, 64'h5);
        chk("first out_rd", XLEN'(out_rd), 64'd3);
        idle();
        tick();

        // back-to-back entries against a stalled consumer
        out_ready = 1'b0;
        set_entry(64'h11, 64'ha1, 5'd1, 3'b100);
        tick();
        set_entry(64'h22, 64'ha2, 5'd2, 3'b110);
        tick();
        chk("full in_ready", XLEN'(in_ready), 64'd0);
        set_entry(64'h33, 64'ha3, 5'd4, 3'b101);
        tick();
        chk("held head", out_result, 64'h11);
        out_ready = 1'b1;
        tick();
        chk("after pop head", out_result, 64'h22);
        out_ready = 1'b0;
        tick();
        idle();
        out_ready = 1'b1;
        tick();
        chk("third in order", out_result, 64'h33);
        tick();
        chk("drained", XLEN'(out_valid), 64'd0);

        // taken blt with an entry buffered
        out_ready = 1'b0;
        set_entry(64'h44, 64'h0, 5'd5, 3'b100);
        tick();
        set_branch(3'b100, 64'd1, 64'd2, 64'h1000);
        tick();
        chk("blt redirect", XLEN'(redirect_valid), 64'd1);
        chk("blt pc", redirect_pc, 64'h1000);
        chk("blt occupancy", XLEN'(out_valid), 64'd1);
        idle();
        tick();
        chk("blt pulse width", XLEN'(redirect_valid), 64'd0);

        // taken branch consumed, buffer fills, then flush with a taken branch
        set_branch(3'b000, 64'd9, 64'd9, 64'h2000);
        tick();
        set_entry(64'h55, 64'h0, 5'd6, 3'b100);
        tick();
        chk("filled", XLEN'(in_ready), 64'd0);
        out_ready = 1'b1;
        set_branch(3'b000, 64'd9, 64'd9, 64'h3000);
        flush = 1'b1;
        tick();
        chk("flush empty", XLEN'(out_valid), 64'd0);
        chk("flush no redirect", XLEN'(redirect_valid), 64'd0);
        idle();
        tick();

        // branch condition table
        for (int i = 0; i < 13; i++) begin
            out_ready = 1'b1;
            set_branch(vecs[i].f3, vecs[i].a, vecs[i].b, 64'h1000 + 64'(i) * 4);
            tick();
`ifdef UNSIGNED_BRANCH_EN
            exp_t = vecs[i].exp_unsigned_build;
`else
            exp_t = vecs[i].exp_signed_build;
`endif
            chk($sformatf("table[%0d] redirect", i), XLEN'(redirect_valid), XLEN'(exp_t));
            idle();
            tick();
        end

        // asynchronous reset while full
        out_ready = 1'b0;
        set_entry(64'h66, 64'h1, 5'd7, 3'b100);
        tick();
        set_entry(64'h77, 64'h2, 5'd8, 3'b100);
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async out_valid", XLEN'(out_valid), 64'd0);
        chk("async in_ready", XLEN'(in_ready), 64'd1);
        chk("async out_result", out_result, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        set_entry(64'h88, 64'h3, 5'd9, 3'b001);
        tick();
        chk("post-reset accept", out_result, 64'h88);
        idle();
        tick();

        // random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            idle();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 3) == 0)
                    set_branch(3'($urandom_range(0, 7)), rand_op(), rand_op(),
                               {$urandom, $urandom});
                else
                    set_entry({$urandom, $urandom}, {$urandom, $urandom},
                              5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_ex_mem.md
BRANCH_EX_MEM -- requirements
Module: branch_ex_mem

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width.
REQ-002 SHALL have parameter DEPTH, fixed at 2, buffer entries; other values are not supported.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream EX entry valid.
REQ-006 SHALL have port in_ready  output  1  buffer can accept an entry.
REQ-007 SHALL have port alu_result  input  XLEN  ALU/SLT result.
REQ-008 SHALL have port alu_zero  input  1  a-b == 0.
REQ-009 SHALL have port alu_less  input  1  signed a<b (diff MSB xor overflow).
REQ-010 SHALL have port alu_cout  input  1  subtract carry-out, 1 means a>=b unsigned.
REQ-011 SHALL have port is_branch  input  1  entry is a conditional branch.
REQ-012 SHALL have port funct3  input  3  branch condition code.
REQ-013 SHALL have port br_target  input  XLEN  taken-branch PC.
REQ-014 SHALL have port store_data  input  XLEN  rs2 data for stores.
REQ-015 SHALL have port rd_addr  input  5  destination register.
REQ-016 SHALL have port ctl  input  3  {reg_write, mem_read, mem_write}.
REQ-017 SHALL have port flush  input  1  discard all buffered entries.
REQ-018 SHALL have port out_valid  output  1  MEM-stage entry valid.
REQ-019 SHALL have port out_ready  input  1  MEM stage accepts.
REQ-020 SHALL have ports out_result, out_store_data, out_rd, out_ctl  output  XLEN/XLEN/5/3  head-entry fields.
REQ-021 SHALL have port redirect_valid  output  1  one-cycle taken-branch pulse.
REQ-022 SHALL have port redirect_pc  output  XLEN  redirect target.

Function
REQ-023 SHALL hold a 2-entry FIFO with states EMPTY, ONE, FULL; in_ready = (state != FULL), out_valid = (state != EMPTY), both decoded from registered state only.
REQ-024 SHALL accept on in_valid & in_ready & !is_branch & !flush, and dequeue on out_valid & out_ready.
REQ-025 SHALL allow simultaneous enqueue and dequeue in ONE, staying ONE with the new entry at head next cycle; in FULL, a dequeue frees a slot but enqueue waits until in_ready is high.
REQ-026 SHALL consume a branch on in_valid & in_ready & is_branch & !flush, never enqueue it, and leave occupancy unchanged.
REQ-027 SHALL evaluate taken: 000 zero, 001 !zero, 100 less, 101 !less, 110 !cout, 111 cout; codes 010/011 are not taken.
REQ-028 SHALL assert redirect_valid exactly one cycle after a taken branch is consumed, with redirect_pc = br_target registered at acceptance; not-taken branches produce no pulse.
REQ-029 SHALL, when flush is high, empty the FIFO next edge, ignore in_valid that cycle, cancel any redirect pulse due next cycle, and not count a concurrent dequeue twice.
REQ-030 SHALL hold out_* fields stable while out_valid & !out_ready; FIFO pointers wrap modulo 2.
REQ-031 SHALL have one-cycle latency from acceptance to out_valid when EMPTY.

Reset
REQ-032 SHALL, on rst_n low, asynchronously force state EMPTY, pointers 0, redirect_valid 0, redirect_pc 0, all out_* data 0.
REQ-033 SHALL discard in-flight entries and pending redirects on reset mid-operation; first acceptance is possible on the first rising edge after rst_n rises.

Configuration
REQ-034 SHALL, with UNSIGNED_BRANCH_EN defined, implement funct3 110 (bltu) and 111 (bgeu) per REQ-027.
REQ-035 SHALL, without UNSIGNED_BRANCH_EN, treat 110/111 as not taken, leave alu_cout unused, and behave otherwise identically.

Verification
REQ-036 SHALL cover: reset, then in_valid with alu_result=0x5, rd=3, ctl=100, out_ready=1 -> out_valid next cycle, out_result=0x5, out_rd=3.
REQ-037 SHALL cover: out_ready=0, three back-to-back entries -> in_ready low after two; third accepted only after one dequeue; order preserved.
REQ-038 SHALL cover: blt with alu_less=1, br_target=0x1000 -> redirect_valid one cycle, redirect_pc=0x1000, out_valid unchanged.
REQ-039 SHALL cover: bgeu with alu_cout=1 -> redirect under UNSIGNED_BRANCH_EN, none without.
REQ-040 SHALL cover: FULL plus a taken branch being consumed, then flush=1 -> next cycle EMPTY, redirect_valid 0.
REQ-041 SHALL cover: rst_n low asynchronously mid-cycle while FULL -> out_valid 0 immediately, before the next clock edge.
